// File: rtl/spi_frame_master.sv
// SPI mode-0 frame master: divided sclk, zero-padded frames,
// MOSI shift-out, 2-FF synchronised MISO shift-in.
module spi_frame_master #(
  parameter int FRAME_BITS = 16,
  parameter int DATA_BITS  = 12,
  parameter int CLK_DIV    = 2,
  parameter int CS_IDLE    = 2
) (
  input  logic                 clk,
  input  logic                 rst_a_n,
  input  logic                 ena,
  input  logic                 start,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 busy,
  output logic                 done,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 sclk_n,
  output logic                 cs_n,
  output logic                 mosi,
  input  logic                 miso
);

  localparam int HW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BW = $clog2(FRAME_BITS + 1);
  localparam int GW = (CS_IDLE > 2) ? $clog2(CS_IDLE - 1) : 1;

  localparam logic [HW-1:0] H_LAST = HW'(CLK_DIV - 1);
  localparam logic [BW-1:0] B_LOAD = BW'(FRAME_BITS);
  localparam logic [GW-1:0] G_LOAD =
    GW'((CS_IDLE > 1) ? CS_IDLE - 2 : 0);

  typedef enum logic [2:0] {
    IDLE, SETUP, SHIFT, HOLD, GAP
  } state_t;

  state_t state, state_d;

  logic [HW-1:0]         hcnt, hcnt_d;
  logic [BW-1:0]         bcnt, bcnt_d;
  logic [GW-1:0]         gcnt, gcnt_d;
  logic [FRAME_BITS-1:0] tx_sr, tx_sr_d;
  logic [DATA_BITS-1:0]  rx_sr, rx_sr_d;
  logic [DATA_BITS-1:0]  rx_d;
  logic                  sclk_n_d, cs_n_d, mosi_d;
  logic                  busy_d, done_d;
  logic [1:0]            sync;
  logic                  miso_s;
  logic [FRAME_BITS-1:0] frame;

  assign frame  = FRAME_BITS'(tx_data);
  assign miso_s = sync[1];

  // The synchroniser ignores ena so miso is never stale after a stall.
  always_ff @(posedge clk or negedge rst_a_n) begin
    if (!rst_a_n) begin
      sync <= 2'b00;
    end else begin
      sync <= {sync[0], miso};
    end
  end

  always_comb begin
    state_d  = state;
    hcnt_d   = hcnt;
    bcnt_d   = bcnt;
    gcnt_d   = gcnt;
    tx_sr_d  = tx_sr;
    rx_sr_d  = rx_sr;
    rx_d     = rx_data;
    sclk_n_d = sclk_n;
    cs_n_d   = cs_n;
    mosi_d   = mosi;
    busy_d   = busy;
    done_d   = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_d  = SETUP;
          tx_sr_d  = frame << 1;
          mosi_d   = frame[FRAME_BITS-1];
          cs_n_d   = 1'b0;
          busy_d   = 1'b1;
          sclk_n_d = 1'b1;
          hcnt_d   = H_LAST;
        end
      end
      SETUP: begin
        if (hcnt == '0) begin
          state_d  = SHIFT;
          sclk_n_d = 1'b0;
          hcnt_d   = H_LAST;
          bcnt_d   = B_LOAD;
        end else begin
          hcnt_d = hcnt - 1'b1;
        end
      end
      SHIFT: begin
        if (hcnt != '0) begin
          hcnt_d = hcnt - 1'b1;
        end else begin
          hcnt_d = H_LAST;
          if (!sclk_n) begin
            // end of high phase: sample, then fall
            rx_sr_d  = DATA_BITS'({rx_sr, miso_s});
            sclk_n_d = 1'b1;
            bcnt_d   = bcnt - 1'b1;
            if (bcnt == BW'(1)) begin
              state_d = HOLD;
              mosi_d  = 1'b0;
            end else begin
              mosi_d  = tx_sr[FRAME_BITS-1];
              tx_sr_d = tx_sr << 1;
            end
          end else begin
            sclk_n_d = 1'b0;
          end
        end
      end
      HOLD: begin
        if (hcnt != '0) begin
          hcnt_d = hcnt - 1'b1;
        end else begin
          cs_n_d = 1'b1;
          done_d = 1'b1;
          rx_d   = rx_sr;
          gcnt_d = G_LOAD;
          // the IDLE cycle is the last cycle of the cs_n gap
          state_d = (CS_IDLE > 1) ? GAP : IDLE;
          busy_d  = (CS_IDLE > 1);
        end
      end
      GAP: begin
        if (gcnt == '0) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          gcnt_d = gcnt - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_a_n) begin
    if (!rst_a_n) begin
      state   <= IDLE;
      hcnt    <= '0;
      bcnt    <= '0;
      gcnt    <= '0;
      tx_sr   <= '0;
      rx_sr   <= '0;
      rx_data <= '0;
      sclk_n  <= 1'b1;
      cs_n    <= 1'b1;
      mosi    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else if (ena) begin
      state   <= state_d;
      hcnt    <= hcnt_d;
      bcnt    <= bcnt_d;
      gcnt    <= gcnt_d;
      tx_sr   <= tx_sr_d;
      rx_sr   <= rx_sr_d;
      rx_data <= rx_d;
      sclk_n  <= sclk_n_d;
      cs_n    <= cs_n_d;
      mosi    <= mosi_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

endmodule

// File: tb/tb_spi_frame_master.sv
// Bench for spi_frame_master: three parameter sets, a slave model
// and a frame-level reference computed from the frame rules.
module tb_spi_frame_master;

  logic        clk = 1'b0;
  logic        rst_a_n = 1'b0;
  logic        ena = 1'b1;
  logic        miso = 1'b0;
  logic        start = 1'b0;
  logic [11:0] tx = '0;
  int          sel = 0;
  logic [2:0]  st;

  logic        busy0, done0, sclk_n0, cs_n0, mosi0;
  logic        busy1, done1, sclk_n1, cs_n1, mosi1;
  logic        busy2, done2, sclk_n2, cs_n2, mosi2;
  logic [11:0] rx0, rx1;
  logic [7:0]  rx2;

  logic        m_busy, m_done, m_sclk_n, m_cs_n, m_mosi;
  logic [15:0] m_rx;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  assign st = {start && sel == 2, start && sel == 1, start && sel == 0};

  spi_frame_master u0 (
    .clk(clk), .rst_a_n(rst_a_n), .ena(ena), .start(st[0]),
    .tx_data(tx), .busy(busy0), .done(done0), .rx_data(rx0),
    .sclk_n(sclk_n0), .cs_n(cs_n0), .mosi(mosi0), .miso(miso)
  );

  spi_frame_master #(.CLK_DIV(3)) u1 (
    .clk(clk), .rst_a_n(rst_a_n), .ena(ena), .start(st[1]),
    .tx_data(tx), .busy(busy1), .done(done1), .rx_data(rx1),
    .sclk_n(sclk_n1), .cs_n(cs_n1), .mosi(mosi1), .miso(miso)
  );

  spi_frame_master #(.FRAME_BITS(8), .DATA_BITS(8)) u2 (
    .clk(clk), .rst_a_n(rst_a_n), .ena(ena), .start(st[2]),
    .tx_data(tx[7:0]), .busy(busy2), .done(done2), .rx_data(rx2),
    .sclk_n(sclk_n2), .cs_n(cs_n2), .mosi(mosi2), .miso(miso)
  );

  always_comb begin
    case (sel)
      1: begin
        m_busy = busy1; m_done = done1; m_sclk_n = sclk_n1;
        m_cs_n = cs_n1; m_mosi = mosi1; m_rx = 16'(rx1);
      end
      2: begin
        m_busy = busy2; m_done = done2; m_sclk_n = sclk_n2;
        m_cs_n = cs_n2; m_mosi = mosi2; m_rx = 16'(rx2);
      end
      default: begin
        m_busy = busy0; m_done = done0; m_sclk_n = sclk_n0;
        m_cs_n = cs_n0; m_mosi = mosi0; m_rx = 16'(rx0);
      end
    endcase
  end

  // frame monitor and slave model
  int          low_q[$];
  int          gap_q[$];
  int          lowcnt = 0, highcnt = 0;
  int          falls = 0, dones = 0, cs_falls = 0, stall_tog = 0;
  int          sidx = 0;
  int          cur_f = 16;
  bit          had_low = 0;
  logic [15:0] mword = '0;
  logic [15:0] sbits = '0;
  logic        ena_q = 1'b1;
  logic        p_cs = 1'b1, p_sclk = 1'b1, p_mosi = 1'b0;
  logic        p_done = 1'b0, p_busy = 1'b0;

  initial forever begin
    @(posedge clk);
    ena_q = ena;
  end

  initial forever begin
    @(negedge clk);
    if (!ena_q && {m_sclk_n, m_cs_n, m_mosi, m_done, m_busy}
        !== {p_sclk, p_cs, p_mosi, p_done, p_busy})
      stall_tog++;
    if (p_cs && !m_cs_n) begin
      if (had_low) gap_q.push_back(highcnt);
      lowcnt = 0; falls = 0; mword = '0; sidx = 0;
      cs_falls++;
      miso = sbits[4'(cur_f - 1)];
    end
    if (!p_cs && m_cs_n) begin
      low_q.push_back(lowcnt);
      highcnt = 0;
      had_low = 1;
    end
    if (!m_cs_n) lowcnt++;
    else highcnt++;
    if (!m_cs_n && p_sclk && !m_sclk_n) begin
      falls++;
      mword = {mword[14:0], m_mosi};
    end
    if (!m_cs_n && !p_sclk && m_sclk_n) begin
      sidx++;
      if (sidx < cur_f) miso = sbits[4'(cur_f - 1 - sidx)];
    end
    if (m_done) dones++;
    p_cs = m_cs_n; p_sclk = m_sclk_n; p_mosi = m_mosi;
    p_done = m_done; p_busy = m_busy;
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    low_q.delete();
    gap_q.delete();
    falls = 0; dones = 0; cs_falls = 0;
    stall_tog = 0; had_low = 0;
  endtask

  task automatic load_slave(input int f, input int d,
                            input logic [15:0] sw);
    logic [15:0] dmask;
    dmask = 16'((32'd1 << d) - 1);
    cur_f = f;
    sbits = (16'($urandom) & ~dmask) | (sw & dmask);
  endtask

  task automatic run_frame(input string name, input int s,
                           input logic [15:0] tx_v,
                           input logic [15:0] sw,
                           input int stall_at, input int stall_len,
                           input int poke_at);
    int f, d, dv, n, lim, exp_low, obs;
    logic [15:0] dmask;
    f = (s == 2) ? 8 : 16;
    d = (s == 2) ? 8 : 12;
    dv = (s == 1) ? 3 : 2;
    dmask = 16'((32'd1 << d) - 1);
    exp_low = (2 * f + 1) * dv + stall_len;
    lim = 400;
    sel = s;
    load_slave(f, d, sw);
    clear_mon();
    @(negedge clk);
    tx = tx_v[11:0];
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    tx = 12'($urandom);
    check({name, "/busy_rise"}, {30'd0, m_busy, m_cs_n}, 32'd2);
    n = 0;
    while (!m_done && n < lim) begin
      @(negedge clk);
      n++;
      if (n == stall_at) ena = 1'b0;
      if (n == stall_at + stall_len) ena = 1'b1;
      start = (n == poke_at);
    end
    ena = 1'b1;
    start = 1'b0;
    check({name, "/done_seen"}, 32'(n < lim), 32'd1);
    repeat (6) @(negedge clk);
    obs = (low_q.size() == 1) ? low_q[0] : -1;
    check({name, "/cs_low"}, 32'(obs), 32'(exp_low));
    check({name, "/sclk_falls"}, 32'(falls), 32'(f));
    check({name, "/mosi"}, 32'(mword), 32'(tx_v & dmask));
    check({name, "/rx_data"}, 32'(m_rx), 32'(sw & dmask));
    check({name, "/done_cnt"}, 32'(dones), 32'd1);
    check({name, "/frames"}, 32'(cs_falls), 32'd1);
    check({name, "/busy_end"}, 32'(m_busy), 32'd0);
    if (stall_len > 0)
      check({name, "/frozen"}, 32'(stall_tog), 32'd0);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    check("reset/ctl", {27'd0, sclk_n0, cs_n0, mosi0, busy0, done0},
          32'h18);
    check("reset/rx", 32'(rx0), 32'd0);
    rst_a_n = 1'b1;
    repeat (3) @(negedge clk);

    run_frame("single", 0, 16'h0A5C, 16'h03C1, 0, 0, 0);
    run_frame("guard", 0, 16'h0A5C, 16'h03C1, 0, 0, 10);
    run_frame("stall", 0, 16'h0A5C, 16'h03C1, 20, 7, 0);

    // asynchronous reset in the middle of a frame
    sel = 0;
    load_slave(16, 12, 16'h0777);
    @(negedge clk);
    tx = 12'h123;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (30) @(negedge clk);
    #2 rst_a_n = 1'b0;
    #1;
    check("rst_mid/ctl", {27'd0, sclk_n0, cs_n0, mosi0, busy0, done0},
          32'h18);
    check("rst_mid/rx", 32'(rx0), 32'd0);
    @(negedge clk);
    rst_a_n = 1'b1;
    repeat (2) @(negedge clk);
    run_frame("post_rst", 0, 16'h0F0F, 16'h0B2D, 0, 0, 0);

    for (int i = 0; i < 3; i++)
      run_frame("rand", 0, 16'($urandom), 16'($urandom), 0, 0, 0);

    run_frame("width8", 2, 16'h0081, 16'h00FF, 0, 0, 0);

    // back-to-back frames with start held high, CLK_DIV=3
    sel = 1;
    load_slave(16, 12, 16'h05A3);
    clear_mon();
    @(negedge clk);
    tx = 12'hC35;
    start = 1'b1;
    n = 0;
    while (low_q.size() < 2 && n < 800) begin
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    check("b2b/two_frames", 32'(n < 800), 32'd1);
    check("b2b/low0", 32'((low_q.size() > 0) ? low_q[0] : -1), 32'd99);
    check("b2b/low1", 32'((low_q.size() > 1) ? low_q[1] : -1), 32'd99);
    check("b2b/gap", 32'((gap_q.size() > 0) ? gap_q[0] : -1), 32'd2);
    check("b2b/mosi", 32'(mword), 32'h0C35);
    repeat (20) @(negedge clk);
    check("b2b/rx_data", 32'(m_rx), 32'h05A3);
    check("b2b/done_cnt", 32'(dones), 32'd2);
    check("b2b/frames", 32'(cs_falls), 32'd2);
    check("b2b/idle", {30'd0, m_busy, m_cs_n}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
